// File: rtl/fifo_w32r8_pkg.sv
// Shared definitions for the program-path page buffer (SRAM w32 -> NAND r8).
// Holds the FSM state encoding, default geometry and the byte-lane helper.
package fifo_w32r8_pkg;

  localparam int unsigned DEF_PAGE_WORDS = 320;
  localparam int unsigned DEF_PAGE_BYTES = 4 * DEF_PAGE_WORDS;
  localparam int unsigned DEF_AW         = 9;
  localparam int unsigned DEF_BW         = 11;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Little-endian lane pick: lane 0 is bits [7:0].
  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/fifo_w32r8_if.sv
// Bus bundle for fifo_w32r8: SRAM-side word write port, NAND-side byte
// stream with valid/ready, page counters and status.
//   master : drives Abort, D, WE, QRdy; observes everything else
//   slave  : the buffer itself
interface fifo_w32r8_if
  import fifo_w32r8_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned BW = DEF_BW
);

  logic          Abort;
  logic [31:0]   D;
  logic          WE;
  logic          WrRdy;
  logic [AW-1:0] WrCnt;
  logic [7:0]    Q;
  logic          QV;
  logic          QRdy;
  logic [BW-1:0] ByteCnt;
  logic          PageDone;
  logic          Busy;

  modport master (
    output Abort, D, WE, QRdy,
    input  WrRdy, WrCnt, Q, QV, ByteCnt, PageDone, Busy
  );

  modport slave (
    input  Abort, D, WE, QRdy,
    output WrRdy, WrCnt, Q, QV, ByteCnt, PageDone, Busy
  );

endinterface

// File: rtl/fifo_w32r8_byte_serializer.sv
// byte_serializer_w32r8: turns 32-bit words from the page RAM into a byte
// stream with valid/ready. Keeps the word being emitted, a one-word holding
// register for the prefetched next word, and the registered output byte.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   flush          synchronous drop of all buffered data
//   rd_data        RAM read data, valid while rd_valid
//   rd_valid       rd_data carries a fresh word this cycle
//   q_rdy          downstream accepts the byte
//   q, qv          registered output byte and valid
//   pf_req_c       request the next word (issued while byte 2 transfers)
//   xfer_c         a byte transfers this cycle
module byte_serializer_w32r8
  import fifo_w32r8_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] rd_data,
  input  logic        rd_valid,
  input  logic        q_rdy,
  output logic [7:0]  q,
  output logic        qv,
  output logic        pf_req_c,
  output logic        xfer_c
);

  logic [31:0] cur_word;
  logic [31:0] hold;
  logic        hold_full;
  logic [1:0]  lane;

  logic        adv_c;
  logic        need_word_c;
  logic        take_word_c;
  logic [31:0] src_c;

  assign xfer_c      = qv && q_rdy;
  assign adv_c       = !qv || q_rdy;
  assign need_word_c = adv_c && (!qv || (lane == 2'd3));
  // Fresh RAM data bypasses the holding register so word boundaries need no bubble.
  assign src_c       = hold_full ? hold : rd_data;
  assign take_word_c = need_word_c && (hold_full || rd_valid);
  assign pf_req_c    = xfer_c && (lane == 2'd2);

  // Output byte, lane pointer and current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= 8'h00;
      qv       <= 1'b0;
      lane     <= 2'd0;
      cur_word <= 32'h0;
    end else if (flush) begin
      q    <= 8'h00;
      qv   <= 1'b0;
      lane <= 2'd0;
    end else if (take_word_c) begin
      cur_word <= src_c;
      q        <= src_c[7:0];
      lane     <= 2'd0;
      qv       <= 1'b1;
    end else if (adv_c && qv && (lane != 2'd3)) begin
      q    <= lane_byte(cur_word, lane + 2'd1);
      lane <= lane + 2'd1;
    end else if (need_word_c) begin
      qv <= 1'b0;
    end
  end

  // Holding register for a prefetched word that could not be consumed at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= 32'h0;
      hold_full <= 1'b0;
    end else if (flush) begin
      hold_full <= 1'b0;
    end else if (take_word_c) begin
      hold_full <= 1'b0;
    end else if (rd_valid) begin
      hold      <= rd_data;
      hold_full <= 1'b1;
    end
  end

endmodule

// File: rtl/fifo_w32r8.sv
// fifo_w32r8: single-page program-path buffer. Loads PAGE_WORDS 32-bit words
// from the SRAM side, then streams the page as little-endian bytes to the
// NAND program sequencer. One page resident at a time.
// Ports:
//   CK      system clock (rising edge)
//   ResetN  asynchronous active-low reset
//   bus     fifo_w32r8_if.slave: Abort, D, WE, WrRdy, WrCnt, Q, QV, QRdy,
//           ByteCnt, PageDone, Busy
module fifo_w32r8
  import fifo_w32r8_pkg::*;
#(
  parameter int unsigned PAGE_WORDS = DEF_PAGE_WORDS,
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned BW         = DEF_BW
) (
  input logic          CK,
  input logic          ResetN,
  fifo_w32r8_if.slave  bus
);

  localparam int unsigned PAGE_BYTES = 4 * PAGE_WORDS;
  localparam int unsigned RAM_AW     = (PAGE_WORDS > 1) ? $clog2(PAGE_WORDS) : 1;

  state_e        state;
  state_e        next_state;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] byte_cnt;
  logic          wr_rdy;
  logic          busy;
  logic          page_done;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic [31:0]   mem [PAGE_WORDS];

  logic          we_c;
  logic          last_word_c;
  logic          last_byte_c;
  logic          rd_en_c;
  logic [AW-1:0] rd_addr_c;
  logic          pf_req_c;
  logic          xfer_c;
  logic [7:0]    q;
  logic          qv;

  assign we_c        = (state == ST_LOAD) && bus.WE && !bus.Abort;
  assign last_word_c = we_c && (wr_cnt == AW'(PAGE_WORDS - 1));
  assign last_byte_c = (state == ST_DRAIN) && xfer_c && (byte_cnt == BW'(PAGE_BYTES - 1));
  // Word 0 is read on the edge that enters DRAIN; later words on prefetch requests.
  assign rd_addr_c   = last_word_c ? '0 : rd_ptr;
  assign rd_en_c     = !bus.Abort &&
                       (last_word_c ||
                        ((state == ST_DRAIN) && pf_req_c && (rd_ptr != AW'(PAGE_WORDS))));

  // Page RAM, one-cycle read latency, contents survive reset.
  always_ff @(posedge CK) begin
    if (we_c) begin
      mem[RAM_AW'(wr_cnt)] <= bus.D;
    end
    if (rd_en_c) begin
      rd_data <= mem[RAM_AW'(rd_addr_c)];
    end
  end

  // State register.
  always_ff @(posedge CK or negedge ResetN) begin
    if (!ResetN) begin
      state <= ST_LOAD;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; Abort overrides everything.
  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD:  if (last_word_c) next_state = ST_DRAIN;
      ST_DRAIN: if (last_byte_c) next_state = ST_DONE;
      ST_DONE:  next_state = ST_LOAD;
      default:  next_state = ST_LOAD;
    endcase
    if (bus.Abort) begin
      next_state = ST_LOAD;
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge CK or negedge ResetN) begin
    if (!ResetN) begin
      wr_rdy    <= 1'b1;
      busy      <= 1'b0;
      page_done <= 1'b0;
    end else begin
      wr_rdy    <= (next_state == ST_LOAD);
      busy      <= (next_state != ST_LOAD);
      page_done <= (next_state == ST_DONE);
    end
  end

  // Page counters and read pointer; cleared on Abort and on leaving DONE.
  always_ff @(posedge CK or negedge ResetN) begin
    if (!ResetN) begin
      wr_cnt   <= '0;
      byte_cnt <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else if (bus.Abort || (state == ST_DONE)) begin
      wr_cnt   <= '0;
      byte_cnt <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en_c;
      if (we_c) begin
        wr_cnt <= wr_cnt + AW'(1);
      end
      if ((state == ST_DRAIN) && xfer_c) begin
        byte_cnt <= byte_cnt + BW'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_addr_c + AW'(1);
      end
    end
  end

  byte_serializer_w32r8 u_ser (
    .clk      (CK),
    .rst_n    (ResetN),
    .flush    (bus.Abort),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .q_rdy    (bus.QRdy),
    .q        (q),
    .qv       (qv),
    .pf_req_c (pf_req_c),
    .xfer_c   (xfer_c)
  );

  assign bus.WrRdy    = wr_rdy;
  assign bus.WrCnt    = wr_cnt;
  assign bus.Q        = q;
  assign bus.QV       = qv;
  assign bus.ByteCnt  = byte_cnt;
  assign bus.PageDone = page_done;
  assign bus.Busy     = busy;

endmodule

// File: tb/tb_fifo_w32r8.sv
// Bench for fifo_w32r8: a full-size instance (320 words) and a 4-word
// instance, driven from one directed sequence with a byte scoreboard.
module tb_fifo_w32r8;

  logic CK;
  logic ResetN;

  fifo_w32r8_if #(.AW(9), .BW(11)) b ();
  fifo_w32r8_if #(.AW(3), .BW(5))  s ();

  fifo_w32r8 #(.PAGE_WORDS(320), .AW(9), .BW(11)) u_big (
    .CK     (CK),
    .ResetN (ResetN),
    .bus    (b)
  );

  fifo_w32r8 #(.PAGE_WORDS(4), .AW(3), .BW(5)) u_small (
    .CK     (CK),
    .ResetN (ResetN),
    .bus    (s)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sb [$];
  logic [7:0] ssb [$];

  logic [31:0] small_words [4] = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
  logic [7:0]  small_bytes [16] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                                    8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h00, 8'hFF, 8'hEE, 8'hDD};

  int d_bytes, d_mism, d_stab, d_pd, d_pd_bad, d_bc_bad, d_wr_bad, d_qv_load;
  int c_last, c_pd, c_wr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Write n words to the large instance; ramp gives word k = {4k+3,4k+2,4k+1,4k}.
  task automatic load_big(input int n, input bit ramp, input bit push);
    logic [31:0] w;
    for (int k = 0; k < n; k++) begin
      w = ramp ? {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)} : $urandom;
      b.D  = w;
      b.WE = 1'b1;
      if (push) for (int j = 0; j < 4; j++) sb.push_back(w[8*j +: 8]);
      tick();
    end
    b.WE = 1'b0;
  endtask

  // Drain the large instance, comparing every transferred byte with the scoreboard.
  task automatic drain_big(input int rdy_pct, input bit junk, input int max_cycles, input int stop_bytes);
    logic [7:0] pq;
    logic [7:0] e;
    logic       pstall;
    d_bytes = 0; d_mism = 0; d_stab = 0; d_pd = 0; d_pd_bad = 0;
    d_bc_bad = 0; d_wr_bad = 0; d_qv_load = 0;
    c_last = -1; c_pd = -1; c_wr = -1;
    pstall = 1'b0; pq = 8'h00;
    for (int c = 0; c < max_cycles; c++) begin
      if (d_bytes == stop_bytes) break;
      if (c_last >= 0 && b.WrRdy === 1'b1) begin
        c_wr = c;
        break;
      end
      if (pstall && (b.QV !== 1'b1 || b.Q !== pq)) d_stab++;
      if (b.WrRdy && b.QV) d_qv_load++;
      if (b.Busy && (b.WrRdy !== 1'b0 || b.WrCnt !== 9'd320)) d_wr_bad++;
      if (b.Busy && b.ByteCnt !== 11'(d_bytes)) d_bc_bad++;
      if (b.PageDone) begin
        d_pd++;
        c_pd = c;
        if (b.QV !== 1'b0 || b.ByteCnt !== 11'd1280) d_pd_bad++;
      end
      b.QRdy = (int'($urandom_range(99)) < rdy_pct);
      b.WE   = junk;
      b.D    = 32'hDEADBEEF;
      if (b.QV && b.QRdy) begin
        if (sb.size() == 0) begin
          d_mism++;
        end else begin
          e = sb.pop_front();
          if (b.Q !== e) d_mism++;
          if (sb.size() == 0) c_last = c;
        end
        d_bytes++;
      end
      pstall = b.QV && !b.QRdy;
      pq     = b.Q;
      tick();
    end
    b.WE   = 1'b0;
    b.QRdy = 1'b0;
  endtask

  task automatic drain_checks(input string t);
    check({t, "_bytes"},       d_bytes, 1280);
    check({t, "_sb_left"},     sb.size(), 0);
    check({t, "_data"},        d_mism, 0);
    check({t, "_hold"},        d_stab, 0);
    check({t, "_pd_count"},    d_pd, 1);
    check({t, "_pd_qv_bcnt"},  d_pd_bad, 0);
    check({t, "_bytecnt"},     d_bc_bad, 0);
    check({t, "_wr_blocked"},  d_wr_bad, 0);
    check({t, "_qv_in_load"},  d_qv_load, 0);
    check({t, "_pd_time"},     c_pd, c_last + 1);
    check({t, "_wrrdy_time"},  c_wr, c_last + 2);
  endtask

  initial begin
    int n;
    int mism;
    int pd;
    logic [7:0] e;

    ResetN = 1'b0;
    b.Abort = 1'b0; b.D = '0; b.WE = 1'b0; b.QRdy = 1'b0;
    s.Abort = 1'b0; s.D = '0; s.WE = 1'b0; s.QRdy = 1'b0;
    repeat (3) @(posedge CK);
    #1;
    ResetN = 1'b1;
    tick();

    // Reset state
    check("rst_wrrdy",    b.WrRdy, 1);
    check("rst_qv",       b.QV, 0);
    check("rst_busy",     b.Busy, 0);
    check("rst_wrcnt",    b.WrCnt, 0);
    check("rst_bytecnt",  b.ByteCnt, 0);
    check("rst_pagedone", b.PageDone, 0);
    check("rst_q",        b.Q, 0);

    // Ramp page, QRdy held high
    load_big(320, 1'b1, 1'b1);
    check("t1_wrcnt_full", b.WrCnt, 320);
    check("t1_wrrdy_low",  b.WrRdy, 0);
    check("t1_busy",       b.Busy, 1);
    check("t1_qv_at_1",    b.QV, 0);
    tick();
    check("t1_qv_at_2",    b.QV, 1);
    check("t1_first_q",    b.Q, 8'h00);
    drain_big(100, 1'b0, 3000, -1);
    drain_checks("t1");
    check("t1_consecutive", c_last, 1279);

    // Ramp page, random backpressure
    load_big(320, 1'b1, 1'b1);
    drain_big(50, 1'b0, 8000, -1);
    drain_checks("t2");

    // Writes attempted throughout the drain are ignored
    load_big(320, 1'b1, 1'b1);
    drain_big(100, 1'b1, 3000, -1);
    drain_checks("t3");
    check("t3_wrcnt_after", b.WrCnt, 0);

    // Abort a partial page, then load and drain a fresh one
    load_big(100, 1'b0, 1'b0);
    check("t4_wrcnt_100", b.WrCnt, 100);
    b.Abort = 1'b1; b.WE = 1'b1; b.D = 32'hDEADBEEF;
    tick();
    b.Abort = 1'b0; b.WE = 1'b0;
    check("t4_wrcnt_cleared", b.WrCnt, 0);
    check("t4_wrrdy",         b.WrRdy, 1);
    check("t4_no_pd",         b.PageDone, 0);
    load_big(320, 1'b0, 1'b1);
    drain_big(70, 1'b0, 6000, -1);
    drain_checks("t4");

    // Asynchronous reset at byte 500 of a drain
    load_big(320, 1'b1, 1'b1);
    drain_big(100, 1'b0, 3000, 500);
    check("t5_bytes_500", d_bytes, 500);
    check("t5_qv_before", b.QV, 1);
    ResetN = 1'b0;
    #1;
    check("t5_qv_async",   b.QV, 0);
    check("t5_busy_async", b.Busy, 0);
    @(posedge CK);
    #1;
    ResetN = 1'b1;
    tick();
    check("t5_wrrdy",   b.WrRdy, 1);
    check("t5_wrcnt",   b.WrCnt, 0);
    check("t5_bytecnt", b.ByteCnt, 0);
    sb.delete();
    load_big(320, 1'b0, 1'b1);
    drain_big(100, 1'b0, 3000, -1);
    drain_checks("t5");

    // Four-word page, Abort together with the last byte
    for (int k = 0; k < 4; k++) begin
      s.D  = small_words[k];
      s.WE = 1'b1;
      for (int j = 0; j < 4; j++) ssb.push_back(small_bytes[4*k+j]);
      tick();
    end
    s.WE = 1'b0;
    check("t6_qv_at_1", s.QV, 0);
    tick();
    check("t6_qv_at_2", s.QV, 1);
    n = 0; mism = 0; pd = 0;
    for (int c = 0; c < 40 && n < 16; c++) begin
      s.QRdy = 1'b1;
      if (s.PageDone) pd++;
      if (s.QV) begin
        e = ssb.pop_front();
        if (s.Q !== e) mism++;
        if (n == 15) s.Abort = 1'b1;
        n++;
      end
      tick();
      s.Abort = 1'b0;
    end
    for (int c = 0; c < 4; c++) begin
      if (s.PageDone) pd++;
      tick();
    end
    s.QRdy = 1'b0;
    check("t6_bytes",   n, 16);
    check("t6_data",    mism, 0);
    check("t6_no_pd",   pd, 0);
    check("t6_qv_off",  s.QV, 0);
    check("t6_wrrdy",   s.WrRdy, 1);
    check("t6_wrcnt",   s.WrCnt, 0);
    check("t6_bytecnt", s.ByteCnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
